// File: rtl/dmem_read_arbiter_pkg.sv
// Shared constants and types for the GPU data-memory read arbiter.
// The owner-tag type changes shape when DMEM_ARB_COALESCE_EN is defined.
package gpu_dmem_pkg;

  localparam int DMEM_NUM_PORTS  = 8;
  localparam int DMEM_ADDR_WIDTH = 15;
  localparam int DMEM_DATA_WIDTH = 32;
  localparam int DMEM_MAX_REQ    = 32;

  typedef logic [2:0] port_idx_t;
  typedef logic [4:0] req_idx_t;

`ifdef DMEM_ARB_COALESCE_EN
  // One bit per requester sharing the port's read.
  typedef logic [DMEM_MAX_REQ-1:0] owner_tag_t;
`else
  typedef struct packed {
    logic     vld;
    req_idx_t idx;
  } owner_tag_t;
`endif

  function automatic req_idx_t wrap_inc(input int idx, input int n);
    return req_idx_t'((idx + 1) % n);
  endfunction

endpackage

// File: rtl/dmem_read_arbiter_if.sv
// Requester-side bus of the dmem read arbiter (request, grant, response).
// Handshake: a request is accepted in the cycle where i_REQ[r] & o_GNT[r]; i_REQ[r]/i_ADDR
// are held until then (or withdrawn). o_RVALID[r] pulses once, exactly 2 cycles after acceptance.
interface dmem_read_arbiter_if
  import gpu_dmem_pkg::*;
#(
  parameter int NUM_REQ    = 16,
  parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = DMEM_DATA_WIDTH
);
  logic [NUM_REQ-1:0]            i_REQ;
  logic [NUM_REQ*ADDR_WIDTH-1:0] i_ADDR;
  logic [NUM_REQ-1:0]            o_GNT;
  logic [NUM_REQ-1:0]            o_RVALID;
  logic [NUM_REQ*DATA_WIDTH-1:0] o_RDATA;

  modport master (output i_REQ, i_ADDR, input o_GNT, o_RVALID, o_RDATA);
  modport slave  (input i_REQ, i_ADDR, output o_GNT, o_RVALID, o_RDATA);
endinterface

// File: rtl/dmem_read_arbiter_rr_multi_picker.sv
// Combinational round-robin picker: grants up to 8 requesters per cycle onto memory ports.
// With DMEM_ARB_COALESCE_EN, requesters hitting an already-allocated address share that port.
module rr_multi_picker
  import gpu_dmem_pkg::*;
#(
  parameter int NUM_REQ    = 16,
  parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH
)
(
  input  logic [NUM_REQ-1:0]                         req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]              addr,
  input  req_idx_t                                   ptr,
  output logic [NUM_REQ-1:0]                         gnt,
  output owner_tag_t [DMEM_NUM_PORTS-1:0]            port_tag,
  output logic [DMEM_NUM_PORTS-1:0][ADDR_WIDTH-1:0]  port_addr,
  output req_idx_t                                   next_ptr
);

  always_comb begin
    int idx;
    int used;
    logic [ADDR_WIDTH-1:0] a;
`ifdef DMEM_ARB_COALESCE_EN
    logic hit;
    hit = 1'b0;
`endif
    gnt       = '0;
    port_tag  = '0;
    port_addr = '0;
    next_ptr  = ptr;
    idx       = 0;
    used      = 0;
    a         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      a   = addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
      if (req[idx]) begin
`ifdef DMEM_ARB_COALESCE_EN
        hit = 1'b0;
        for (int p = 0; p < DMEM_NUM_PORTS; p++) begin
          if (!hit && p < used && port_addr[p] == a) begin
            hit              = 1'b1;
            gnt[idx]         = 1'b1;
            port_tag[p][idx] = 1'b1;
            next_ptr         = wrap_inc(idx, NUM_REQ);
          end
        end
        if (!hit && used < DMEM_NUM_PORTS) begin
          gnt[idx]            = 1'b1;
          port_tag[used][idx] = 1'b1;
          port_addr[used]     = a;
          used                = used + 1;
          next_ptr            = wrap_inc(idx, NUM_REQ);
        end
`else
        if (used < DMEM_NUM_PORTS) begin
          gnt[idx]           = 1'b1;
          port_tag[used].vld = 1'b1;
          port_tag[used].idx = req_idx_t'(idx);
          port_addr[used]    = a;
          used               = used + 1;
          next_ptr           = wrap_inc(idx, NUM_REQ);
        end
`endif
      end
    end
  end

endmodule

// File: rtl/dmem_read_arbiter.sv
// Shares the 8 synchronous dmem read ports among NUM_REQ requesters; fixed 2-cycle latency.
// Define DMEM_ARB_COALESCE_EN to let same-address requests share one port.
module dmem_read_arbiter
  import gpu_dmem_pkg::*;
#(
  parameter int NUM_REQ    = 16,
  parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = DMEM_DATA_WIDTH
)
(
  input  logic                                 i_CLK,
  input  logic                                 i_RST,
  dmem_read_arbiter_if.slave                   rq,
  output logic [DMEM_NUM_PORTS*ADDR_WIDTH-1:0] o_DMEM_ADDR,
  input  logic [DMEM_NUM_PORTS*DATA_WIDTH-1:0] i_DMEM_RDATA,
  output logic [31:0]                          o_STALL_CNT,
  output req_idx_t                             o_DBG_PTR
);

  req_idx_t                                  ptr_q;
  req_idx_t                                  next_ptr;
  logic [NUM_REQ-1:0]                        req_live;
  logic [NUM_REQ-1:0]                        gnt;
  owner_tag_t [DMEM_NUM_PORTS-1:0]           tag_d;
  owner_tag_t [DMEM_NUM_PORTS-1:0]           tag_q;
  logic [DMEM_NUM_PORTS-1:0][ADDR_WIDTH-1:0] port_addr;
  logic [DMEM_NUM_PORTS-1:0][DATA_WIDTH-1:0] port_rdata;
  logic [NUM_REQ-1:0]                        rvalid_d;
  logic [NUM_REQ-1:0]                        rvalid_q;
  logic [NUM_REQ*DATA_WIDTH-1:0]             rdata_d;
  logic [NUM_REQ*DATA_WIDTH-1:0]             rdata_q;
  logic                                      stall;

  // Masking requests during reset forces o_GNT low and keeps tags empty.
  assign req_live = i_RST ? '0 : rq.i_REQ;

  rr_multi_picker #(
    .NUM_REQ    (NUM_REQ),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_picker (
    .req       (req_live),
    .addr      (rq.i_ADDR),
    .ptr       (ptr_q),
    .gnt       (gnt),
    .port_tag  (tag_d),
    .port_addr (port_addr),
    .next_ptr  (next_ptr)
  );

  assign rq.o_GNT    = gnt;
  assign rq.o_RVALID = rvalid_q;
  assign rq.o_RDATA  = rdata_q;
  assign o_DMEM_ADDR = port_addr;
  assign port_rdata  = i_DMEM_RDATA;
  assign o_DBG_PTR   = ptr_q;
  assign stall       = |(rq.i_REQ & ~gnt);

  // Stage 1: owner tags captured on the same edge the dmem samples its addresses.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      ptr_q <= '0;
      tag_q <= '0;
    end else begin
      ptr_q <= next_ptr;
      tag_q <= tag_d;
    end
  end

  always_comb begin
    rvalid_d = '0;
    rdata_d  = rdata_q;
    for (int r = 0; r < NUM_REQ; r++) begin
      for (int p = 0; p < DMEM_NUM_PORTS; p++) begin
`ifdef DMEM_ARB_COALESCE_EN
        if (tag_q[p][r]) begin
`else
        if (tag_q[p].vld && tag_q[p].idx == req_idx_t'(r)) begin
`endif
          rvalid_d[r]                         = 1'b1;
          rdata_d[r*DATA_WIDTH +: DATA_WIDTH] = port_rdata[p];
        end
      end
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      rvalid_q    <= '0;
      rdata_q     <= '0;
      o_STALL_CNT <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      if (stall && o_STALL_CNT != 32'hFFFF_FFFF)
        o_STALL_CNT <= o_STALL_CNT + 32'd1;
    end
  end

endmodule

// File: tb/tb_dmem_read_arbiter.sv
// Bench for dmem_read_arbiter: directed scenarios plus random traffic against a queue-based
// model of the round-robin rules; honours DMEM_ARB_COALESCE_EN like the design.
module tb_dmem_read_arbiter;
  import gpu_dmem_pkg::*;

  localparam int NR = 16;
  localparam int AW = DMEM_ADDR_WIDTH;
  localparam int DW = DMEM_DATA_WIDTH;
  localparam int NP = DMEM_NUM_PORTS;

  logic             clk;
  logic             i_rst;
  logic [NP*AW-1:0] dmem_addr;
  logic [NP*DW-1:0] dmem_rdata;
  logic [31:0]      stall_cnt;
  req_idx_t         dbg_ptr;

  dmem_read_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) rq ();

  dmem_read_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_CLK        (clk),
    .i_RST        (i_rst),
    .rq           (rq),
    .o_DMEM_ADDR  (dmem_addr),
    .i_DMEM_RDATA (dmem_rdata),
    .o_STALL_CNT  (stall_cnt),
    .o_DBG_PTR    (dbg_ptr)
  );

  // ---------------- clock / reset / dmem model ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    if (a == 15'h0010) return 32'hDEADBEEF;
    if (a == 15'h0100) return 32'hCAFE0100;
    return {a[7:0] ^ 8'hA5, 1'b0, a, 8'h3C};
  endfunction

  always @(posedge clk)
    for (int p = 0; p < NP; p++)
      dmem_rdata[p*DW +: DW] <= mem_val(dmem_addr[p*AW +: AW]);

  // ---------------- scoreboard state ----------------
  logic [55:0]   exp_q[$];   // {due cycle[15:0], requester[7:0], data[31:0]}
  int            n_chk = 0;
  int            n_pass = 0;
  logic          mon_en = 1'b0;
  int            m_ptr = 0;
  longint        m_stall = 0;
  logic [DW-1:0] last_data [NR];
  logic [NR-1:0] pend = '0;
  logic [NR*AW-1:0] paddr = '0;
  logic [NR-1:0] last_eg;
  logic [NR-1:0] last_act_gnt;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic rst, input logic [NR-1:0] req, input logic [NR*AW-1:0] addr);
    logic [NR-1:0]    eg;
    logic [NP*AW-1:0] ea;
    int               order[$];
    logic [AW-1:0]    ports[$];
    int               last;
    int               r;
    int               slot;
    logic [AW-1:0]    a;
    @(negedge clk);
    i_rst     = rst;
    rq.i_REQ  = req;
    rq.i_ADDR = addr;
    #1;
    eg = '0; ea = '0; last = -1;
    if (!rst) begin
      for (int i = 0; i < NR; i++)
        if (req[(m_ptr + i) % NR]) order.push_back((m_ptr + i) % NR);
      foreach (order[j]) begin
        r    = order[j];
        a    = addr[r*AW +: AW];
        slot = -1;
`ifdef DMEM_ARB_COALESCE_EN
        foreach (ports[k]) if (ports[k] == a) slot = k;
`endif
        if (slot < 0 && ports.size() < NP) begin
          ports.push_back(a);
          slot = ports.size() - 1;
        end
        if (slot >= 0) begin
          eg[r] = 1'b1;
          last  = r;
          exp_q.push_back({16'(cyc + 2), 8'(r), mem_val(a)});
        end
      end
      foreach (ports[k]) ea[k*AW +: AW] = ports[k];
    end
    chk("gnt", 128'(rq.o_GNT), 128'(eg));
    chk("dmem_addr", 128'(dmem_addr), 128'(ea));
    if (mon_en) begin
      chk("stall_cnt", 128'(stall_cnt), 128'(m_stall));
      chk("ptr", 128'(dbg_ptr), 128'(m_ptr));
    end
    last_eg      = eg;
    last_act_gnt = rq.o_GNT;
    if (rst) begin
      for (int k = exp_q.size() - 1; k >= 0; k--)
        if (int'(exp_q[k][55:40]) > cyc) exp_q.delete(k);
      m_ptr   = 0;
      m_stall = 0;
      for (int k = 0; k < NR; k++) last_data[k] = '0;
    end else begin
      if (last >= 0) m_ptr = (last + 1) % NR;
      if (|(req & ~eg)) m_stall++;
    end
  endtask

  // Drives the pending set; granted requests retire, the rest stay held.
  task automatic run(input logic rst);
    step(rst, pend, paddr);
    pend = pend & ~last_eg;
  endtask

  task automatic set_req(input int r, input logic [AW-1:0] a);
    pend[r] = 1'b1;
    paddr[r*AW +: AW] = a;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : mon
    logic [NR-1:0] ev;
    logic [DW-1:0] ed [NR];
    logic [NR*DW-1:0] hold;
    int r;
    if (mon_en) begin
      ev = '0;
      for (int k = 0; k < NR; k++) ed[k] = '0;
      for (int k = exp_q.size() - 1; k >= 0; k--) begin
        if (int'(exp_q[k][55:40]) == cyc) begin
          r = int'(exp_q[k][39:32]);
          ev[r] = 1'b1;
          ed[r] = exp_q[k][31:0];
          exp_q.delete(k);
        end
      end
      chk("rvalid", 128'(rq.o_RVALID), 128'(ev));
      for (int k = 0; k < NR; k++) begin
        if (ev[k]) begin
          chk($sformatf("rdata[%0d]", k), 128'(rq.o_RDATA[k*DW +: DW]), 128'(ed[k]));
          last_data[k] = ed[k];
        end
      end
      for (int k = 0; k < NR; k++) hold[k*DW +: DW] = last_data[k];
      chk("rdata_hold", 128'(rq.o_RDATA), 128'(hold));
    end
  end

  // ---------------- stimulus ----------------
  initial begin : drv
    int cnt [NR];
    int lastg [NR];
    int maxgap;
    i_rst = 1'b1;
    rq.i_REQ = '0;
    rq.i_ADDR = '0;
    for (int k = 0; k < NR; k++) last_data[k] = '0;

    // Reset with every requester asserting: no grants.
    pend = '1;
    run(1'b1);
    mon_en = 1'b1;
    run(1'b1);
    pend = '0;
    run(1'b0);

    // Single request r=5 at 0x10.
    set_req(5, 15'h0010);
    repeat (4) run(1'b0);

    // All 16 with distinct addresses: two cycles, stall counted once.
    for (int r = 0; r < NR; r++) set_req(r, AW'(16'h0200 + r));
    repeat (5) run(1'b0);

    // Reset mid-flight: grant r=8, reset next cycle, response must vanish.
    set_req(8, 15'h0123);
    run(1'b0);
    run(1'b1);
    repeat (3) run(1'b0);

    // Fairness: 0..9 held continuously for 6 cycles.
    for (int r = 0; r < NR; r++) begin cnt[r] = 0; lastg[r] = -1; end
    maxgap = 0;
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 16'h03FF, paddr);
      for (int r = 0; r < 10; r++) begin
        if (last_act_gnt[r]) begin
          cnt[r]++;
          if (lastg[r] >= 0 && c - lastg[r] > maxgap) maxgap = c - lastg[r];
          lastg[r] = c;
        end
      end
    end
    for (int r = 0; r < 10; r++)
      chk($sformatf("fair_cnt[%0d]", r), 128'(cnt[r] >= 4 && cnt[r] <= 5), 128'(1));
    chk("fair_gap", 128'(maxgap <= 2), 128'(1));
    pend = '0;
    repeat (3) run(1'b0);

    // Same address from all 16 requesters.
    for (int r = 0; r < NR; r++) set_req(r, 15'h0100);
    repeat (5) run(1'b0);

    // Random traffic: holds, withdrawals, address reuse, occasional reset.
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < NR; r++) begin
        if (!pend[r] && $urandom_range(0, 2) == 0)
          set_req(r, ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15)));
        else if (pend[r] && $urandom_range(0, 19) == 0)
          pend[r] = 1'b0;
      end
      run($urandom_range(0, 99) == 0);
    end
    pend = '0;
    repeat (4) run(1'b0);
    chk("drain", 128'(exp_q.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
